// File: rtl/pwm_multi.sv
// Multi-channel center-aligned PWM with a shared up/down carrier, prescaler and
// per-channel breathing ramp; thresholds are shadow-loaded at each carrier period boundary.
module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESC_W    = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      mclk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [PRESC_W-1:0]        presc,
    input  logic [7:0]                step_div,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      period_start
);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

    localparam logic [WIDTH-1:0]    MAX  = '1;
    localparam logic [WIDTH-1:0]    ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic                ACT  = (ACTIVE_LOW == 0);
    localparam logic [CHANNELS-1:0] IDLE = {CHANNELS{~ACT}};

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    dir_e                cdir_q, cdir_d;
    logic [PRESC_W-1:0]  pc_q, pc_d;
    logic [7:0]          sc_q, sc_d;
    logic [WIDTH-1:0]    thr_q [CHANNELS];
    logic [WIDTH-1:0]    thr_d [CHANNELS];
    dir_e                bdir_q [CHANNELS];
    dir_e                bdir_d [CHANNELS];
    logic                mode_q, mode_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                ps_q, ps_d;

    logic tick;
    logic boundary;
    logic mode_eff;

    assign tick     = en && (pc_q == presc);
    assign boundary = tick && (cnt_q == '0);
    // The threshold update at a boundary must see the mode sampled at that same boundary.
    assign mode_eff = boundary ? mode : mode_q;

    always_comb begin
        cnt_d  = cnt_q;
        cdir_d = cdir_q;
        pc_d   = pc_q;
        sc_d   = sc_q;
        thr_d  = thr_q;
        bdir_d = bdir_q;
        mode_d = mode_q;
        pwm_d  = pwm_q;
        ps_d   = boundary;

        if (en) begin
            pc_d = tick ? '0 : pc_q + 1'b1;
        end else begin
            pwm_d = IDLE;
        end

        if (tick) begin
            if (cdir_q == UP) begin
                if (cnt_q == MAX) begin
                    cdir_d = DOWN;
                    cnt_d  = MAX - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cdir_d = UP;
                    cnt_d  = ONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_d[i] = ((thr_q[i] == MAX) || (cnt_q < thr_q[i])) ? ACT : ~ACT;
            end
        end

        if (boundary) begin
            mode_d = mode;
            if (!mode_eff) begin
                sc_d = '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    thr_d[i]  = duty[i*WIDTH +: WIDTH];
                    bdir_d[i] = (duty[i*WIDTH +: WIDTH] == MAX) ? DOWN : UP;
                end
            end else if (sc_q == step_div) begin
                sc_d = '0;
                // Bounce at the rails so the ramp never dwells at 0 or MAX.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (thr_q[i] == MAX) begin
                        bdir_d[i] = DOWN;
                        thr_d[i]  = thr_q[i] - 1'b1;
                    end else if (thr_q[i] == '0) begin
                        bdir_d[i] = UP;
                        thr_d[i]  = thr_q[i] + 1'b1;
                    end else if (bdir_q[i] == UP) begin
                        thr_d[i] = thr_q[i] + 1'b1;
                    end else begin
                        thr_d[i] = thr_q[i] - 1'b1;
                    end
                end
            end else begin
                sc_d = sc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            cdir_q <= UP;
            pc_q   <= '0;
            sc_q   <= '0;
            mode_q <= 1'b0;
            pwm_q  <= IDLE;
            ps_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                thr_q[i]  <= '0;
                bdir_q[i] <= UP;
            end
        end else begin
            cnt_q  <= cnt_d;
            cdir_q <= cdir_d;
            pc_q   <= pc_d;
            sc_q   <= sc_d;
            mode_q <= mode_d;
            pwm_q  <= pwm_d;
            ps_q   <= ps_d;
            thr_q  <= thr_d;
            bdir_q <= bdir_d;
        end
    end

    assign pwm_o        = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (WIDTH=4, 4 channels, active-low outputs): duty tables,
// prescaler, breathing ramp, enable hold and asynchronous reset.
module tb_pwm_multi;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [7:0]  presc;
    logic [7:0]  step_div;
    logic [15:0] duty;
    logic [3:0]  pwm_o;
    logic        period_start;

    int checks   = 0;
    int failures = 0;

    int act [4];
    bit ps_ok;
    bit step_ok;
    int waited;
    bit hold_ok;

    typedef struct packed {
        logic [15:0]     duty;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [3];

    // Active clocks per 30-clock period while breathing with step_div=0, from reset.
    int bexp [31] = '{1, 3, 5, 7, 9, 11, 13, 15, 17, 19, 21, 23, 25, 27, 30,
                      27, 25, 23, 21, 19, 17, 15, 13, 11, 9, 7, 5, 3, 1, 0, 1};
    int sexp [6]  = '{3, 3, 3, 5, 5, 5};

    always #5 mclk = ~mclk;

    pwm_multi #(
        .WIDTH     (4),
        .CHANNELS  (4),
        .PRESC_W   (8),
        .ACTIVE_LOW(1)
    ) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .presc       (presc),
        .step_div    (step_div),
        .duty        (duty),
        .pwm_o       (pwm_o),
        .period_start(period_start)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Advance to the next negedge that shows period_start, bounded.
    task automatic sync_ps(output int n);
        n = 0;
        @(negedge mclk);
        n++;
        while (!period_start && n < 1000) begin
            @(negedge mclk);
            n++;
        end
        if (!period_start) begin
            checks++;
            failures++;
            $display("FAIL sync_ps timeout actual=none expected=period_start");
        end
    endtask

    // Starting on a period_start sample, count active samples k=1..len, optionally
    // changing duty at sample chg_at; pwm may only change where k is a multiple of step.
    task automatic measure(input int len, input int chg_at, input logic [15:0] chg_duty,
                           input int step);
        logic [3:0] prev;
        prev = pwm_o;
        for (int c = 0; c < 4; c++) act[c] = 0;
        ps_ok   = 1'b1;
        step_ok = 1'b1;
        for (int k = 1; k <= len; k++) begin
            if (k == chg_at) duty = chg_duty;
            @(negedge mclk);
            for (int c = 0; c < 4; c++) if (pwm_o[c] == 1'b0) act[c]++;
            if (pwm_o != prev && (k % step) != 0) step_ok = 1'b0;
            prev = pwm_o;
            if (period_start != (k == len)) ps_ok = 1'b0;
        end
    endtask

    initial begin
        vecs[0].duty = 16'h10F5; vecs[0].exp = {8'd1,  8'd0,  8'd30, 8'd9};
        vecs[1].duty = 16'h2E7A; vecs[1].exp = {8'd3,  8'd27, 8'd13, 8'd19};
        vecs[2].duty = 16'h6C38; vecs[2].exp = {8'd11, 8'd23, 8'd5,  8'd15};

        rst_n = 1'b0; en = 1'b0; mode = 1'b0; presc = 8'd0; step_div = 8'd0; duty = 16'h0;
        repeat (3) @(negedge mclk);
        check("reset_pwm", int'(pwm_o), 15);
        check("reset_ps", int'(period_start), 0);
        en = 1'b1;
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) begin
            duty = vecs[v].duty;
            sync_ps(waited);
            measure(30, 0, 16'h0, 1);
            for (int c = 0; c < 4; c++)
                check($sformatf("fixed_v%0d_ch%0d", v, c), act[c], int'(vecs[v].exp[c]));
            check($sformatf("fixed_v%0d_spacing", v), int'(ps_ok), 1);
        end

        duty = 16'h10F5;
        sync_ps(waited);
        measure(30, 0, 16'h0, 1);
        check("midchg_before", act[0], 9);
        measure(30, 10, 16'h10FA, 1);
        check("midchg_old_holds", act[0], 9);
        measure(30, 0, 16'h0, 1);
        check("midchg_new", act[0], 19);
        check("midchg_spacing", int'(ps_ok), 1);

        presc = 8'd3;
        sync_ps(waited);
        measure(120, 0, 16'h0, 4);
        check("presc3_ch0", act[0], 76);
        check("presc3_ch1", act[1], 120);
        check("presc3_ch2", act[2], 0);
        check("presc3_spacing", int'(ps_ok), 1);
        check("presc3_step", int'(step_ok), 1);
        presc = 8'd0;

        sync_ps(waited);
        repeat (3) @(negedge mclk);
        en = 1'b0;
        @(negedge mclk);
        check("en_off_pwm", int'(pwm_o), 15);
        check("en_off_ps", int'(period_start), 0);
        hold_ok = 1'b1;
        repeat (19) begin
            @(negedge mclk);
            if (pwm_o != 4'hF || period_start) hold_ok = 1'b0;
        end
        check("en_off_hold", int'(hold_ok), 1);
        en = 1'b1;
        @(negedge mclk);
        check("en_resume_pwm0", int'(pwm_o[0]), 0);
        sync_ps(waited);
        check("en_resume_cnt", waited, 26);

        repeat (5) @(negedge mclk);
        mode = 1'b1;
        step_div = 8'd0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_o), 15);
        check("async_rst_ps", int'(period_start), 0);
        repeat (3) @(negedge mclk);
        check("rst_hold_pwm", int'(pwm_o), 15);
        rst_n = 1'b1;
        sync_ps(waited);
        check("rst_cnt_zero", waited, 1);

        for (int n = 0; n < 31; n++) begin
            measure(30, 0, 16'h0, 1);
            for (int c = 0; c < 4; c++)
                check($sformatf("breathe_w%0d_ch%0d", n, c), act[c], bexp[n]);
        end

        step_div = 8'd2;
        for (int n = 0; n < 6; n++) begin
            measure(30, 0, 16'h0, 1);
            check($sformatf("breathe_div2_w%0d", n), act[0], sexp[n]);
        end
        check("breathe_spacing", int'(ps_ok), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
